// File: rtl/mem_arbiter_if.sv
// AXI4-Lite channel bundle shared between the memory arbiter (M side) and
// the unified memory port (S side).
interface if_axi4_lite #(
   parameter int ADDRLEN = 32,
   parameter int XLEN    = 32,
   parameter int STRBLEN = XLEN / 8
);
   logic               awvalid;
   logic               awready;
   logic [ADDRLEN-1:0] awaddr;
   logic [2:0]         awprot;
   logic               wvalid;
   logic               wready;
   logic [XLEN-1:0]    wdata;
   logic [STRBLEN-1:0] wstrb;
   logic               bvalid;
   logic               bready;
   logic [1:0]         bresp;
   logic               arvalid;
   logic               arready;
   logic [ADDRLEN-1:0] araddr;
   logic [2:0]         arprot;
   logic               rvalid;
   logic               rready;
   logic [XLEN-1:0]    rdata;
   logic [1:0]         rresp;

   modport M (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport S (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between the fetch
// unit and the LSU, with a single outstanding transaction at a time.
module mem_arbiter #(
   parameter int XLEN    = 32,
   parameter int ADDRLEN = XLEN,
   parameter int STRBLEN = XLEN / 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_if_req_valid,
   output logic               o_if_req_ready,
   input  logic [ADDRLEN-1:0] i_if_req_addr,
   output logic               o_if_rsp_valid,
   input  logic               i_if_rsp_ready,
   output logic [XLEN-1:0]    o_if_rsp_data,
   output logic               o_if_rsp_err,
   input  logic               i_ls_req_valid,
   output logic               o_ls_req_ready,
   input  logic               i_ls_req_we,
   input  logic [ADDRLEN-1:0] i_ls_req_addr,
   input  logic [XLEN-1:0]    i_ls_req_wdata,
   input  logic [STRBLEN-1:0] i_ls_req_wstrb,
   output logic               o_ls_rsp_valid,
   input  logic               i_ls_rsp_ready,
   output logic [XLEN-1:0]    o_ls_rsp_rdata,
   output logic               o_ls_rsp_err,
   if_axi4_lite.M             m_axi
);

   typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RSP} state_t;
   typedef enum logic {OWNER_IF, OWNER_LS} owner_t;

   state_t             state;
   state_t             state_d;
   owner_t             owner;
   owner_t             last_grant;
   logic [ADDRLEN-1:0] addr_q;
   logic [XLEN-1:0]    wdata_q;
   logic [STRBLEN-1:0] wstrb_q;
   logic               aw_done;
   logic               w_done;
   logic [XLEN-1:0]    rsp_data;
   logic               rsp_err;

   logic grant_if;
   logic grant_ls;
   logic if_hs;
   logic ls_hs;
   logic aw_hs;
   logic w_hs;
   logic owner_rsp_ready;
   logic unused_resp_bits;

   // On contention the requester that did not win last time gets the port.
   assign grant_if = i_if_req_valid && (!i_ls_req_valid || last_grant == OWNER_LS);
   assign grant_ls = i_ls_req_valid && (!i_if_req_valid || last_grant == OWNER_IF);

   assign o_if_req_ready = rstn && (state == IDLE) && grant_if;
   assign o_ls_req_ready = rstn && (state == IDLE) && grant_ls;

   assign if_hs = i_if_req_valid && o_if_req_ready;
   assign ls_hs = i_ls_req_valid && o_ls_req_ready;
   assign aw_hs = m_axi.awvalid && m_axi.awready;
   assign w_hs  = m_axi.wvalid && m_axi.wready;

   assign owner_rsp_ready = (owner == OWNER_IF) ? i_if_rsp_ready : i_ls_rsp_ready;

   // AXI outputs depend on state and captured fields only, never on a ready.
   assign m_axi.arvalid = (state == AR);
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = (owner == OWNER_IF) ? 3'b100 : 3'b000;
   assign m_axi.rready  = (state == R);
   assign m_axi.awvalid = (state == AWW) && !aw_done;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.wvalid  = (state == AWW) && !w_done;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   assign m_axi.bready  = (state == B);

   assign o_if_rsp_valid = (state == RSP) && (owner == OWNER_IF);
   assign o_if_rsp_data  = rsp_data;
   assign o_if_rsp_err   = rsp_err;
   assign o_ls_rsp_valid = (state == RSP) && (owner == OWNER_LS);
   assign o_ls_rsp_rdata = rsp_data;
   assign o_ls_rsp_err   = rsp_err;

   // Only the SLVERR/DECERR bit of the response codes is reported upstream.
   assign unused_resp_bits = m_axi.rresp[0] ^ m_axi.bresp[0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Write leaves AWW once both address and data have been accepted, whether
   // earlier (registered) or in this very cycle.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (if_hs || (ls_hs && !i_ls_req_we)) begin
               state_d = AR;
            end else if (ls_hs) begin
               state_d = AWW;
            end
         end
         AR: begin
            if (m_axi.arready) begin
               state_d = R;
            end
         end
         R: begin
            if (m_axi.rvalid) begin
               state_d = RSP;
            end
         end
         AWW: begin
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_d = B;
            end
         end
         B: begin
            if (m_axi.bvalid) begin
               state_d = RSP;
            end
         end
         RSP: begin
            if (owner_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         owner      <= OWNER_IF;
         last_grant <= OWNER_LS;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         if (if_hs) begin
            owner      <= OWNER_IF;
            last_grant <= OWNER_IF;
            addr_q     <= i_if_req_addr;
         end else if (ls_hs) begin
            owner      <= OWNER_LS;
            last_grant <= OWNER_LS;
            addr_q     <= i_ls_req_addr;
            wdata_q    <= i_ls_req_wdata;
            wstrb_q    <= i_ls_req_wstrb;
         end

         if (if_hs || ls_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else if (state == AWW) begin
            if (aw_hs) begin
               aw_done <= 1'b1;
            end
            if (w_hs) begin
               w_done <= 1'b1;
            end
         end

         if ((state == R) && m_axi.rvalid) begin
            rsp_data <= m_axi.rdata;
            rsp_err  <= m_axi.rresp[1];
         end else if ((state == B) && m_axi.bvalid) begin
            rsp_data <= '0;
            rsp_err  <= m_axi.bresp[1];
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a configurable-latency AXI4-Lite slave plus
// a negedge monitor feeding hand-computed checks.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_if_req_valid;
   logic        o_if_req_ready;
   logic [31:0] i_if_req_addr;
   logic        o_if_rsp_valid;
   logic        i_if_rsp_ready;
   logic [31:0] o_if_rsp_data;
   logic        o_if_rsp_err;
   logic        i_ls_req_valid;
   logic        o_ls_req_ready;
   logic        i_ls_req_we;
   logic [31:0] i_ls_req_addr;
   logic [31:0] i_ls_req_wdata;
   logic [3:0]  i_ls_req_wstrb;
   logic        o_ls_rsp_valid;
   logic        i_ls_rsp_ready;
   logic [31:0] o_ls_rsp_rdata;
   logic        o_ls_rsp_err;

   if_axi4_lite #(.ADDRLEN(32), .XLEN(32), .STRBLEN(4)) m_axi ();

   mem_arbiter #(.XLEN(32), .ADDRLEN(32), .STRBLEN(4)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .i_if_req_valid (i_if_req_valid),
      .o_if_req_ready (o_if_req_ready),
      .i_if_req_addr  (i_if_req_addr),
      .o_if_rsp_valid (o_if_rsp_valid),
      .i_if_rsp_ready (i_if_rsp_ready),
      .o_if_rsp_data  (o_if_rsp_data),
      .o_if_rsp_err   (o_if_rsp_err),
      .i_ls_req_valid (i_ls_req_valid),
      .o_ls_req_ready (o_ls_req_ready),
      .i_ls_req_we    (i_ls_req_we),
      .i_ls_req_addr  (i_ls_req_addr),
      .i_ls_req_wdata (i_ls_req_wdata),
      .i_ls_req_wstrb (i_ls_req_wstrb),
      .o_ls_rsp_valid (o_ls_rsp_valid),
      .i_ls_rsp_ready (i_ls_rsp_ready),
      .o_ls_rsp_rdata (o_ls_rsp_rdata),
      .o_ls_rsp_err   (o_ls_rsp_err),
      .m_axi          (m_axi)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   int          ar_wait, r_wait, aw_wait, w_wait;
   int          ar_cnt, r_cnt, aw_cnt, w_cnt;
   logic [31:0] slave_rdata;
   logic [1:0]  slave_rresp, slave_bresp;

   logic        grant_q[$];
   int          hs_q[$];
   int          ar_cyc, ar_cycles, aw_cycles, w_cycles;
   logic        ar_unstable;
   logic [31:0] ar_addr, aw_addr, w_data;
   logic [2:0]  ar_prot, aw_prot;
   logic [3:0]  w_strb;
   int          if_rsp_cyc, ls_rsp_cyc, if_rsp_hs, ls_rsp_hs;
   logic [31:0] if_rsp_data, ls_rsp_data, stall_data;
   logic        if_rsp_err, ls_rsp_err;
   int          stall_cycles;
   logic        stall_unstable, ls_ready_in_stall, ar_in_stall;

   // Slave answers first, then the monitor records what the next posedge commits.
   always @(negedge clk) begin
      if (!rstn) begin
         m_axi.arready = 1'b0;
         m_axi.rvalid  = 1'b0;
         m_axi.rdata   = '0;
         m_axi.rresp   = '0;
         m_axi.awready = 1'b0;
         m_axi.wready  = 1'b0;
         m_axi.bvalid  = 1'b0;
         m_axi.bresp   = '0;
         ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
         if (m_axi.arvalid) begin
            if (ar_cnt == ar_wait) m_axi.arready = 1'b1;
            else begin m_axi.arready = 1'b0; ar_cnt++; end
         end else begin m_axi.arready = 1'b0; ar_cnt = 0; end
         if (m_axi.rready) begin
            if (r_cnt == r_wait) begin
               m_axi.rvalid = 1'b1; m_axi.rdata = slave_rdata; m_axi.rresp = slave_rresp;
            end else begin m_axi.rvalid = 1'b0; r_cnt++; end
         end else begin m_axi.rvalid = 1'b0; r_cnt = 0; end
         if (m_axi.awvalid) begin
            if (aw_cnt == aw_wait) m_axi.awready = 1'b1;
            else begin m_axi.awready = 1'b0; aw_cnt++; end
         end else begin m_axi.awready = 1'b0; aw_cnt = 0; end
         if (m_axi.wvalid) begin
            if (w_cnt == w_wait) m_axi.wready = 1'b1;
            else begin m_axi.wready = 1'b0; w_cnt++; end
         end else begin m_axi.wready = 1'b0; w_cnt = 0; end
         m_axi.bvalid = m_axi.bready;
         m_axi.bresp  = slave_bresp;
      end

      if (i_if_req_valid && o_if_req_ready) begin grant_q.push_back(1'b0); hs_q.push_back(cyc); end
      if (i_ls_req_valid && o_ls_req_ready) begin grant_q.push_back(1'b1); hs_q.push_back(cyc); end
      if (m_axi.arvalid) begin
         if (ar_cycles == 0) begin ar_cyc = cyc; ar_addr = m_axi.araddr; ar_prot = m_axi.arprot; end
         else if (m_axi.araddr != ar_addr || m_axi.arprot != ar_prot) ar_unstable = 1'b1;
         ar_cycles++;
      end
      if (m_axi.awvalid) begin
         if (aw_cycles == 0) begin aw_addr = m_axi.awaddr; aw_prot = m_axi.awprot; end
         aw_cycles++;
      end
      if (m_axi.wvalid) begin
         if (w_cycles == 0) begin w_data = m_axi.wdata; w_strb = m_axi.wstrb; end
         w_cycles++;
      end
      if (o_if_rsp_valid) begin
         if (if_rsp_cyc < 0) begin if_rsp_cyc = cyc; if_rsp_data = o_if_rsp_data; if_rsp_err = o_if_rsp_err; end
         if (i_if_rsp_ready) if_rsp_hs++;
         else begin
            if (stall_cycles == 0) stall_data = o_if_rsp_data;
            else if (o_if_rsp_data != stall_data) stall_unstable = 1'b1;
            if (o_ls_req_ready) ls_ready_in_stall = 1'b1;
            if (m_axi.arvalid) ar_in_stall = 1'b1;
            stall_cycles++;
         end
      end
      if (o_ls_rsp_valid) begin
         if (ls_rsp_cyc < 0) begin ls_rsp_cyc = cyc; ls_rsp_data = o_ls_rsp_rdata; ls_rsp_err = o_ls_rsp_err; end
         if (i_ls_rsp_ready) ls_rsp_hs++;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clearLog();
      grant_q.delete();
      hs_q.delete();
      ar_cyc = -1; ar_cycles = 0; ar_unstable = 1'b0;
      aw_cycles = 0; w_cycles = 0;
      if_rsp_cyc = -1; ls_rsp_cyc = -1; if_rsp_hs = 0; ls_rsp_hs = 0;
      stall_cycles = 0; stall_unstable = 1'b0; ls_ready_in_stall = 1'b0; ar_in_stall = 1'b0;
   endtask

   task automatic applyStimulus(input logic if_v, input logic [31:0] if_a,
                                input logic ls_v, input logic ls_we, input logic [31:0] ls_a,
                                input logic [31:0] ls_d, input logic [3:0] ls_s);
      i_if_req_valid = if_v;
      i_if_req_addr  = if_a;
      i_ls_req_valid = ls_v;
      i_ls_req_we    = ls_we;
      i_ls_req_addr  = ls_a;
      i_ls_req_wdata = ls_d;
      i_ls_req_wstrb = ls_s;
   endtask

   // Waits for one more request handshake, then withdraws both requests.
   task automatic waitHandshake(input string tag);
      int   n0;
      logic ok;
      n0 = grant_q.size();
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk); #1;
         if (grant_q.size() > n0) ok = 1'b1;
      end
      @(posedge clk); #1;
      i_if_req_valid = 1'b0;
      i_ls_req_valid = 1'b0;
      checkOutput({tag, "_handshake"}, ok, 1'b1);
   endtask

   task automatic waitRsp(input string tag, input int target);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk); #1;
         if (if_rsp_hs + ls_rsp_hs >= target) ok = 1'b1;
      end
      @(posedge clk); #1;
      checkOutput({tag, "_response"}, ok, 1'b1);
   endtask

   task automatic pulseReset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   logic exp_grant[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic ok_flag;

   initial begin
      rstn = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      i_if_rsp_ready = 1'b1;
      i_ls_rsp_ready = 1'b1;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0;
      slave_rdata = 32'h0000_0013; slave_rresp = 2'b00; slave_bresp = 2'b00;
      clearLog();
      #1;
      checkOutput("reset_axi", {m_axi.arvalid, m_axi.rready, m_axi.awvalid, m_axi.wvalid, m_axi.bready}, '0);
      checkOutput("reset_req_rsp", {o_if_req_ready, o_ls_req_ready, o_if_rsp_valid, o_ls_rsp_valid}, '0);
      checkOutput("reset_rsp_data", {o_if_rsp_err, o_if_rsp_data}, '0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      $display("[TB] single IF read");
      clearLog();
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, '0);
      waitHandshake("t1");
      waitRsp("t1", 1);
      checkOutput("t1_araddr", ar_addr, 32'h40);
      checkOutput("t1_arprot", ar_prot, 3'b100);
      checkOutput("t1_ar_latency", ar_cyc - hs_q[0], 1);
      checkOutput("t1_rsp_latency", if_rsp_cyc - hs_q[0], 3);
      checkOutput("t1_rsp_data", if_rsp_data, 32'h13);
      checkOutput("t1_rsp_err", if_rsp_err, 1'b0);
      checkOutput("t1_ls_rsp_silent", ls_rsp_cyc, -1);

      $display("[TB] contention from reset");
      pulseReset();
      clearLog();
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h100, '0, '0);
      ok_flag = 1'b0;
      for (int i = 0; i < 60 && !ok_flag; i++) begin
         @(negedge clk); #1;
         if (grant_q.size() >= 5) ok_flag = 1'b1;
      end
      @(posedge clk); #1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      checkOutput("t2_five_grants", ok_flag, 1'b1);
      waitRsp("t2", 5);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("t2_grant%0d", i), grant_q[i], exp_grant[i]);
      checkOutput("t2_period", hs_q[1] - hs_q[0], 4);
      checkOutput("t2_rsp_split", {if_rsp_hs[7:0], ls_rsp_hs[7:0]}, {8'd3, 8'd2});

      $display("[TB] LS write with staggered wready");
      clearLog();
      aw_wait = 0; w_wait = 2; slave_rdata = 32'hCAFE_F00D;
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'b0011);
      waitHandshake("t3");
      waitRsp("t3", 1);
      checkOutput("t3_awaddr", aw_addr, 32'h80);
      checkOutput("t3_awprot", aw_prot, 3'b000);
      checkOutput("t3_wdata", w_data, 32'hDEAD_BEEF);
      checkOutput("t3_wstrb", w_strb, 4'b0011);
      checkOutput("t3_aw_cycles", aw_cycles, 1);
      checkOutput("t3_w_cycles", w_cycles, 3);
      checkOutput("t3_rsp_latency", ls_rsp_cyc - hs_q[0], 5);
      checkOutput("t3_rsp_rdata", ls_rsp_data, 32'h0);
      checkOutput("t3_rsp_err", ls_rsp_err, 1'b0);
      checkOutput("t3_if_rsp_silent", if_rsp_cyc, -1);

      $display("[TB] LS read with SLVERR and slow arready");
      clearLog();
      w_wait = 0; ar_wait = 3; slave_rdata = 32'h1234_5678; slave_rresp = 2'b10;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h44, '0, '0);
      waitHandshake("t4");
      waitRsp("t4", 1);
      checkOutput("t4_ar_cycles", ar_cycles, 4);
      checkOutput("t4_ar_stable", ar_unstable, 1'b0);
      checkOutput("t4_araddr", ar_addr, 32'h44);
      checkOutput("t4_arprot", ar_prot, 3'b000);
      checkOutput("t4_rsp_latency", ls_rsp_cyc - hs_q[0], 6);
      checkOutput("t4_rsp_err", ls_rsp_err, 1'b1);
      checkOutput("t4_rsp_rdata", ls_rsp_data, 32'h1234_5678);
      clearLog();
      ar_wait = 0; slave_rdata = 32'h0000_0093; slave_rresp = 2'b00;
      applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, '0, '0, '0);
      waitHandshake("t4b");
      waitRsp("t4b", 1);
      checkOutput("t4b_rsp_data", if_rsp_data, 32'h93);
      checkOutput("t4b_rsp_err", if_rsp_err, 1'b0);

      $display("[TB] IF response backpressure with LS pending");
      clearLog();
      i_if_rsp_ready = 1'b0;
      slave_rdata = 32'hAAAA_5555;
      applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, '0);
      waitHandshake("t5");
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h60, '0, '0);
      ok_flag = 1'b0;
      for (int i = 0; i < 20 && !ok_flag; i++) begin
         @(negedge clk); #1;
         if (o_if_rsp_valid) ok_flag = 1'b1;
      end
      checkOutput("t5_if_rsp_seen", ok_flag, 1'b1);
      repeat (5) @(posedge clk);
      #1 i_if_rsp_ready = 1'b1;
      waitHandshake("t5_ls");
      waitRsp("t5", 2);
      checkOutput("t5_stall_cycles", stall_cycles, 5);
      checkOutput("t5_stall_stable", stall_unstable, 1'b0);
      checkOutput("t5_ls_ready_in_stall", ls_ready_in_stall, 1'b0);
      checkOutput("t5_ar_in_stall", ar_in_stall, 1'b0);
      checkOutput("t5_if_rsp_data", if_rsp_data, 32'hAAAA_5555);
      checkOutput("t5_second_grant", grant_q[1], 1'b1);
      checkOutput("t5_ls_rsp_data", ls_rsp_data, 32'hAAAA_5555);

      $display("[TB] reset during R");
      clearLog();
      r_wait = 10;
      applyStimulus(1'b1, 32'h70, 1'b0, 1'b0, '0, '0, '0);
      waitHandshake("t6");
      ok_flag = 1'b0;
      for (int i = 0; i < 20 && !ok_flag; i++) begin
         @(negedge clk); #1;
         if (m_axi.rready) ok_flag = 1'b1;
      end
      checkOutput("t6_in_r", ok_flag, 1'b1);
      rstn = 1'b0;
      #1;
      checkOutput("t6_reset_outputs",
                  {m_axi.arvalid, m_axi.rready, m_axi.awvalid, m_axi.wvalid, m_axi.bready,
                   o_if_rsp_valid, o_ls_rsp_valid, o_if_req_ready, o_ls_req_ready}, '0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      r_wait = 0;
      slave_rdata = 32'h0000_0EEF;
      clearLog();
      repeat (5) @(posedge clk);
      #1;
      checkOutput("t6_no_stale_rsp", if_rsp_hs + ls_rsp_hs, 0);
      checkOutput("t6_no_stale_ar", ar_cycles, 0);
      applyStimulus(1'b1, 32'h74, 1'b1, 1'b0, 32'h78, '0, '0);
      waitHandshake("t6b");
      waitRsp("t6b", 1);
      checkOutput("t6b_grant", grant_q[0], 1'b0);
      checkOutput("t6b_araddr", ar_addr, 32'h74);
      checkOutput("t6b_rsp_data", if_rsp_data, 32'h0000_0EEF);
      checkOutput("t6b_ls_rsp_silent", ls_rsp_hs, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
